// File: rtl/id_ex_pipeline_register_pkg.sv
// Shared definitions for the ID/EX pipeline register.
// Holds the control-bundle bit layout, the register-zero index, the bubble
// control value and the stage update selector.
package id_ex_pipeline_register_pkg;

    localparam int unsigned CTRL_W = 13;

    // Control bundle layout, MSB first:
    // {BranchNE, BranchEQ, ALUOp[2:0], RegWrite, MemWrite, MemRead,
    //  MemtoReg, RegisterOrPC, ALUMemOrPC, JumpControl, UsesRt}
    localparam int unsigned CTRL_BRANCHNE     = 12;
    localparam int unsigned CTRL_BRANCHEQ     = 11;
    localparam int unsigned CTRL_ALUOP_HI     = 10;
    localparam int unsigned CTRL_ALUOP_LO     = 8;
    localparam int unsigned CTRL_REGWRITE     = 7;
    localparam int unsigned CTRL_MEMWRITE     = 6;
    localparam int unsigned CTRL_MEMREAD      = 5;
    localparam int unsigned CTRL_MEMTOREG     = 4;
    localparam int unsigned CTRL_REGISTERORPC = 3;
    localparam int unsigned CTRL_ALUMEMORPC   = 2;
    localparam int unsigned CTRL_JUMPCONTROL  = 1;
    localparam int unsigned CTRL_USESRT       = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // All-zero control: RegWrite=0 and MemWrite=0, so a bubble has no side effect.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // What the stage loads on the next rising edge.
    typedef enum logic [1:0] {
        UpdCapture,
        UpdHold,
        UpdBubble
    } upd_e;

endpackage

// File: rtl/id_ex_pipeline_register_load_use_hazard_detector.sv
// Combinational load-use hazard detector.
// Raises stall_o when the instruction in EX is a valid load writing a non-zero
// register that the valid decode instruction reads (rs always, rt only when
// the decode instruction uses it). Suppressed during flush or hold.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_reg_write_i, ex_write_register_i : EX load info
//   id_valid_i, id_rs_i, id_rt_i, id_uses_rt_i                     : decode sources
//   flush_i, hold_i                                                : suppression
//   stall_o                                                        : stall request
module load_use_hazard_detector
    import id_ex_pipeline_register_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_reg_write_i,
    input  logic [4:0] ex_write_register_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       flush_i,
    input  logic       hold_i,
    output logic       stall_o
);

    logic ex_is_load;
    logic src_match;

    always_comb begin
        ex_is_load = ex_valid_i && ex_mem_read_i && ex_reg_write_i &&
                     (ex_write_register_i != REG_ZERO);
        src_match  = (ex_write_register_i == id_rs_i) ||
                     ((ex_write_register_i == id_rt_i) && id_uses_rt_i);
        // A flush squashes the decode instruction anyway and a hold freezes the
        // stage, so neither may add a bubble.
        stall_o    = ex_is_load && id_valid_i && src_match && !flush_i && !hold_i;
    end

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register for the 32-bit MIPS pipeline.
// Captures decode control, register indices, operands and PC+4 each cycle,
// inserts a bubble on flush or load-use stall, and freezes on hold.
// Edge priority: flush > hold > stall > capture.
// Ports:
//   clk_i, reset_i (async, active-high), flush_i, hold_i
//   id_*_i  : decode-stage instruction fields
//   stall_o : combinational load-use stall to PC and IF/ID register
//   ex_*_o  : registered EX-stage fields
// Optional: define ID_EX_PERF_COUNTERS_EN to add bubble_count_o and
// flush_count_o (32-bit, wrapping, frozen while hold_i=1).
module id_ex_pipeline_register
    import id_ex_pipeline_register_pkg::*;
#(
    parameter int unsigned NBits = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             hold_i,
    input  logic             id_valid_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic [4:0]       id_write_register_i,
    input  logic [NBits-1:0] id_read_data1_i,
    input  logic [NBits-1:0] id_read_data2_i,
    input  logic [NBits-1:0] id_alu_b_i,
    input  logic [NBits-1:0] id_alu_a_i,
    input  logic [NBits-1:0] id_pc_plus4_i,
    output logic             stall_o,
    output logic             ex_valid_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [4:0]       ex_rs_o,
    output logic [4:0]       ex_rt_o,
    output logic [4:0]       ex_write_register_o,
    output logic [NBits-1:0] ex_read_data1_o,
    output logic [NBits-1:0] ex_read_data2_o,
    output logic [NBits-1:0] ex_alu_a_o,
    output logic [NBits-1:0] ex_alu_b_o,
    output logic [NBits-1:0] ex_pc_plus4_o
`ifdef ID_EX_PERF_COUNTERS_EN
    ,
    output logic [31:0]      bubble_count_o,
    output logic [31:0]      flush_count_o
`endif
);

    logic             valid_q, valid_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [4:0]       rs_q, rs_d;
    logic [4:0]       rt_q, rt_d;
    logic [4:0]       wr_q, wr_d;
    logic [NBits-1:0] rd1_q, rd1_d;
    logic [NBits-1:0] rd2_q, rd2_d;
    logic [NBits-1:0] alu_a_q, alu_a_d;
    logic [NBits-1:0] alu_b_q, alu_b_d;
    logic [NBits-1:0] pc4_q, pc4_d;
    upd_e             upd;

    load_use_hazard_detector u_hazard (
        .ex_valid_i          (valid_q),
        .ex_mem_read_i       (ctrl_q[CTRL_MEMREAD]),
        .ex_reg_write_i      (ctrl_q[CTRL_REGWRITE]),
        .ex_write_register_i (wr_q),
        .id_valid_i          (id_valid_i),
        .id_rs_i             (id_rs_i),
        .id_rt_i             (id_rt_i),
        .id_uses_rt_i        (id_ctrl_i[CTRL_USESRT]),
        .flush_i             (flush_i),
        .hold_i              (hold_i),
        .stall_o             (stall_o)
    );

    always_comb begin
        if (flush_i) begin
            upd = UpdBubble;
        end else if (hold_i) begin
            upd = UpdHold;
        end else if (stall_o) begin
            upd = UpdBubble;
        end else begin
            upd = UpdCapture;
        end
    end

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        wr_d    = wr_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        pc4_d   = pc4_q;
        unique case (upd)
            UpdBubble: begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_BUBBLE;
                rs_d    = REG_ZERO;
                rt_d    = REG_ZERO;
                wr_d    = REG_ZERO;
                rd1_d   = '0;
                rd2_d   = '0;
                alu_a_d = '0;
                alu_b_d = '0;
                pc4_d   = '0;
            end
            UpdCapture: begin
                valid_d = id_valid_i;
                // An empty decode slot must never carry live control into EX.
                ctrl_d  = id_valid_i ? id_ctrl_i : CTRL_BUBBLE;
                rs_d    = id_rs_i;
                rt_d    = id_rt_i;
                wr_d    = id_write_register_i;
                rd1_d   = id_read_data1_i;
                rd2_d   = id_read_data2_i;
                alu_a_d = id_alu_a_i;
                alu_b_d = id_alu_b_i;
                pc4_d   = id_pc_plus4_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
            rs_q    <= REG_ZERO;
            rt_q    <= REG_ZERO;
            wr_q    <= REG_ZERO;
            rd1_q   <= '0;
            rd2_q   <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            wr_q    <= wr_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            pc4_q   <= pc4_d;
        end
    end

    assign ex_valid_o          = valid_q;
    assign ex_ctrl_o           = ctrl_q;
    assign ex_rs_o             = rs_q;
    assign ex_rt_o             = rt_q;
    assign ex_write_register_o = wr_q;
    assign ex_read_data1_o     = rd1_q;
    assign ex_read_data2_o     = rd2_q;
    assign ex_alu_a_o          = alu_a_q;
    assign ex_alu_b_o          = alu_b_q;
    assign ex_pc_plus4_o       = pc4_q;

`ifdef ID_EX_PERF_COUNTERS_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (!hold_i && flush_i) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
        // stall_o is already low under flush or hold.
        if (stall_o) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_count_o = bubble_cnt_q;
    assign flush_count_o  = flush_cnt_q;
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
module tb_id_ex_pipeline_register;

    typedef struct packed {
        logic        valid;
        logic [12:0] ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc4;
    } stage_t;

    // {BNE,BEQ,ALUOp[2:0],RegWrite,MemWrite,MemRead,MemtoReg,RegOrPC,ALUMemOrPC,Jump,UsesRt}
    localparam logic [12:0] LW       = 13'h0B0; // RegWrite, MemRead, MemtoReg
    localparam logic [12:0] ADD      = 13'h281; // ALUOp=010, RegWrite, UsesRt
    localparam logic [12:0] ADD_NORT = 13'h280; // as ADD but UsesRt=0

    logic        clk;
    logic        reset;
    logic        flush;
    logic        hold;
    stage_t      id_s;
    stage_t      dut_ex;
    stage_t      model;
    stage_t      expv;
    stage_t      sb[$];
    logic        stall;
    logic        ex_valid;
    logic [12:0] ex_ctrl;
    logic [4:0]  ex_rs, ex_rt, ex_wr;
    logic [31:0] ex_rd1, ex_rd2, ex_a, ex_b, ex_pc4;
    int          tests;
    int          fails;
    int          exp_bubbles;
    int          exp_flushes;
`ifdef ID_EX_PERF_COUNTERS_EN
    logic [31:0] bubble_count, flush_count;
`endif

    id_ex_pipeline_register #(
        .NBits (32)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .flush_i             (flush),
        .hold_i              (hold),
        .id_valid_i          (id_s.valid),
        .id_ctrl_i           (id_s.ctrl),
        .id_rs_i             (id_s.rs),
        .id_rt_i             (id_s.rt),
        .id_write_register_i (id_s.wr),
        .id_read_data1_i     (id_s.rd1),
        .id_read_data2_i     (id_s.rd2),
        .id_alu_b_i          (id_s.b),
        .id_alu_a_i          (id_s.a),
        .id_pc_plus4_i       (id_s.pc4),
        .stall_o             (stall),
        .ex_valid_o          (ex_valid),
        .ex_ctrl_o           (ex_ctrl),
        .ex_rs_o             (ex_rs),
        .ex_rt_o             (ex_rt),
        .ex_write_register_o (ex_wr),
        .ex_read_data1_o     (ex_rd1),
        .ex_read_data2_o     (ex_rd2),
        .ex_alu_a_o          (ex_a),
        .ex_alu_b_o          (ex_b),
        .ex_pc_plus4_o       (ex_pc4)
`ifdef ID_EX_PERF_COUNTERS_EN
        ,
        .bubble_count_o      (bubble_count),
        .flush_count_o       (flush_count)
`endif
    );

    assign dut_ex = {ex_valid, ex_ctrl, ex_rs, ex_rt, ex_wr, ex_rd1, ex_rd2, ex_a, ex_b, ex_pc4};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_id(input logic v, input logic [12:0] c, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] wr, input logic [31:0] seed);
        id_s.valid = v;
        id_s.ctrl  = c;
        id_s.rs    = rs;
        id_s.rt    = rt;
        id_s.wr    = wr;
        id_s.rd1   = seed;
        id_s.rd2   = seed + 32'h11;
        id_s.a     = seed + 32'h22;
        id_s.b     = seed + 32'h33;
        id_s.pc4   = seed + 32'h44;
    endtask

    task automatic check_stage(input string tag, input stage_t want);
        tests++;
        assert (dut_ex === want) else begin
            fails++;
            $error("FAIL %s: ex=%h, expected %h", tag, dut_ex, want);
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef ID_EX_PERF_COUNTERS_EN
        tests++;
        assert (bubble_count === 32'(exp_bubbles)) else begin
            fails++;
            $error("FAIL %s_bubbles: count=%0d, expected %0d", tag, bubble_count, exp_bubbles);
        end
        tests++;
        assert (flush_count === 32'(exp_flushes)) else begin
            fails++;
            $error("FAIL %s_flushes: count=%0d, expected %0d", tag, flush_count, exp_flushes);
        end
`else
        if (tag.len() == 0) $display("[TB] empty tag");
`endif
    endtask

    // One clock of stimulus: check stall, predict the next EX contents, clock, compare.
    task automatic step(input logic fl, input logic ho, input logic exp_stall, input string tag);
        stage_t nxt;
        flush = fl;
        hold  = ho;
        #1;
        tests++;
        assert (stall === exp_stall) else begin
            fails++;
            $error("FAIL %s_stall: stall=%b, expected %b", tag, stall, exp_stall);
        end
        if (fl) begin
            nxt = '0;
        end else if (ho) begin
            nxt = model;
        end else if (exp_stall) begin
            nxt = '0;
        end else begin
            nxt = id_s;
            if (!id_s.valid) nxt.ctrl = '0;
        end
        if (!ho && fl) exp_flushes++;
        if (!ho && !fl && exp_stall) exp_bubbles++;
        sb.push_back(nxt);
        model = nxt;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_queue: scoreboard empty, expected one entry", tag);
        end else begin
            expv = sb.pop_front();
            check_stage(tag, expv);
        end
        flush = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        exp_bubbles = 0;
        exp_flushes = 0;
        model       = '0;
        reset       = 1'b1;
        flush       = 1'b0;
        hold        = 1'b0;

        // Reset with non-zero decode inputs.
        set_id(1'b1, ADD, 5'd1, 5'd2, 5'd3, 32'h1000);
        id_s.b = 32'h0000_0010;
        repeat (2) @(posedge clk);
        #1;
        check_stage("reset_state", '0);
        tests++;
        assert (stall === 1'b0) else begin
            fails++;
            $error("FAIL reset_stall: stall=%b, expected 0", stall);
        end
        check_counters("reset");
        reset = 1'b0;

        step(1'b0, 1'b0, 1'b0, "first_capture");
        tests++;
        assert (ex_b === 32'h0000_0010) else begin
            fails++;
            $error("FAIL first_alu_b: ex_alu_b=%h, expected 00000010", ex_b);
        end

        // Load-use on rs.
        set_id(1'b1, LW, 5'd29, 5'd8, 5'd8, 32'h2000);
        step(1'b0, 1'b0, 1'b0, "lw_rs_load");
        set_id(1'b1, ADD, 5'd8, 5'd10, 5'd11, 32'h3000);
        step(1'b0, 1'b0, 1'b1, "lu_rs_bubble");
        step(1'b0, 1'b0, 1'b0, "lu_rs_capture");

        // rt match without UsesRt: no stall.
        set_id(1'b1, LW, 5'd29, 5'd8, 5'd8, 32'h4000);
        step(1'b0, 1'b0, 1'b0, "lw_nort_load");
        set_id(1'b1, ADD_NORT, 5'd9, 5'd8, 5'd12, 32'h5000);
        step(1'b0, 1'b0, 1'b0, "nort_capture");

        // rt match with UsesRt: stall.
        set_id(1'b1, LW, 5'd29, 5'd8, 5'd8, 32'h6000);
        step(1'b0, 1'b0, 1'b0, "lw_rt_load");
        set_id(1'b1, ADD, 5'd9, 5'd8, 5'd13, 32'h7000);
        step(1'b0, 1'b0, 1'b1, "lu_rt_bubble");
        step(1'b0, 1'b0, 1'b0, "lu_rt_capture");

        // Load to register 0 never stalls.
        set_id(1'b1, LW, 5'd29, 5'd0, 5'd0, 32'h8000);
        step(1'b0, 1'b0, 1'b0, "lw_zero_load");
        set_id(1'b1, ADD, 5'd0, 5'd0, 5'd14, 32'h9000);
        step(1'b0, 1'b0, 1'b0, "zero_reg_capture");

        // Flush with a stall condition present.
        set_id(1'b1, LW, 5'd29, 5'd8, 5'd8, 32'hA000);
        step(1'b0, 1'b0, 1'b0, "lw_flush_load");
        set_id(1'b1, ADD, 5'd8, 5'd8, 5'd15, 32'hB000);
        step(1'b1, 1'b0, 1'b0, "flush_over_stall");
        step(1'b0, 1'b0, 1'b0, "after_flush_capture");
        step(1'b1, 1'b1, 1'b0, "flush_with_hold");

        // Hold for three cycles with changing decode inputs.
        set_id(1'b1, ADD, 5'd3, 5'd4, 5'd20, 32'hC000);
        step(1'b0, 1'b0, 1'b0, "pre_hold_capture");
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, ADD_NORT, 5'(i + 1), 5'(i + 2), 5'(i + 21), 32'hD000 + 32'(i) * 32'h100);
            step(1'b0, 1'b1, 1'b0, $sformatf("hold_%0d", i));
        end

        // Hold suppresses a pending load-use stall; it fires on release.
        set_id(1'b1, LW, 5'd29, 5'd8, 5'd8, 32'hE000);
        step(1'b0, 1'b0, 1'b0, "lw_hold_load");
        set_id(1'b1, ADD, 5'd8, 5'd2, 5'd16, 32'hF000);
        step(1'b0, 1'b1, 1'b0, "hold_masks_stall");
        step(1'b0, 1'b0, 1'b1, "stall_after_hold");
        step(1'b0, 1'b0, 1'b0, "capture_after_hold");

        // Invalid decode slot: no stall and control is zeroed.
        set_id(1'b1, LW, 5'd29, 5'd8, 5'd8, 32'h1_0000);
        step(1'b0, 1'b0, 1'b0, "lw_invalid_load");
        set_id(1'b0, ADD, 5'd8, 5'd8, 5'd17, 32'h1_1000);
        step(1'b0, 1'b0, 1'b0, "id_invalid_capture");
        check_counters("final");

        // Asynchronous reset mid-operation.
        set_id(1'b1, ADD, 5'd5, 5'd6, 5'd7, 32'h1_2000);
        step(1'b0, 1'b0, 1'b0, "pre_reset_capture");
        reset = 1'b1;
        #1;
        check_stage("async_reset", '0);
        @(posedge clk);
        #1;
        check_stage("reset_held", '0);
        reset       = 1'b0;
        model       = '0;
        exp_bubbles = 0;
        exp_flushes = 0;
        check_counters("after_reset");
        step(1'b0, 1'b0, 1'b0, "post_reset_capture");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
